// File: rtl/rv64_pkg.sv
// Shared RV64I definitions for the load/writeback path: load funct3 encodings,
// writeback FSM states and the datapath width.
package rv64_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction and extension, plus the misalignment /
// illegal-encoding check for a given funct3 and byte offset.
module load_align
    import rv64_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] rdata,
    output logic [63:0] data,
    output logic        misaligned
);

    logic [63:0] shifted;

    // Bring the addressed byte lane down to bit 0 before sizing.
    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{56{shifted[7]}}, shifted[7:0]};
            F3_LBU: data = {56'd0, shifted[7:0]};
            F3_LH: begin
                data       = {{48{shifted[15]}}, shifted[15:0]};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {48'd0, shifted[15:0]};
                misaligned = offset[0];
            end
            F3_LW: begin
                data       = {{32{shifted[31]}}, shifted[31:0]};
                misaligned = (offset[1:0] != 2'b00);
            end
            F3_LWU: begin
                data       = {32'd0, shifted[31:0]};
                misaligned = (offset[1:0] != 2'b00);
            end
            F3_LD: begin
                data       = rdata;
                misaligned = (offset != 3'b000);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_wb_unit.sv
// Writeback stage: retires non-loads in one cycle, runs the dmem read handshake
// for loads, and drives the register file write port from registered outputs.
module load_wb_unit
    import rv64_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    output logic            dmem_req,
    output logic [XLEN-1:0] dmem_addr,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_en,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      rd_index,
    output logic            load_fault,
    output logic [XLEN-1:0] fault_addr,
    output logic            busy
);

    wb_state_t       state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            dmem_req_q, dmem_req_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic            wb_en_q, wb_en_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      rd_index_q, rd_index_d;
    logic            load_fault_q, load_fault_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic [4:0]      rd_q, rd_d;
    logic            rd_we_q, rd_we_d;
    logic [2:0]      f3_q, f3_d;
    logic [2:0]      off_q, off_d;

    logic            accept;
    logic [2:0]      al_f3;
    logic [2:0]      al_off;
    logic [XLEN-1:0] al_data;
    logic            al_mis;

    assign accept = in_valid && in_ready_q;

    // One aligner serves both the accept-time check and the ack-time extraction.
    assign al_f3  = (state_q == REQ) ? f3_q  : in_funct3;
    assign al_off = (state_q == REQ) ? off_q : in_addr[2:0];

    load_align u_align (
        .funct3     (al_f3),
        .offset     (al_off),
        .rdata      (dmem_rdata),
        .data       (al_data),
        .misaligned (al_mis)
    );

    always_comb begin
        state_d      = state_q;
        dmem_addr_d  = dmem_addr_q;
        wb_en_d      = 1'b0;
        wb_data_d    = wb_data_q;
        rd_index_d   = rd_index_q;
        load_fault_d = 1'b0;
        fault_addr_d = fault_addr_q;
        rd_d         = rd_q;
        rd_we_d      = rd_we_q;
        f3_d         = f3_q;
        off_d        = off_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_is_load) begin
                        wb_en_d    = in_rd_we && (in_rd != 5'd0);
                        wb_data_d  = in_alu_result;
                        rd_index_d = in_rd;
                    end else if (al_mis) begin
                        load_fault_d = 1'b1;
                        fault_addr_d = in_addr;
                    end else begin
                        rd_d        = in_rd;
                        rd_we_d     = in_rd_we;
                        f3_d        = in_funct3;
                        off_d       = in_addr[2:0];
                        dmem_addr_d = {in_addr[XLEN-1:3], 3'b000};
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    wb_en_d    = rd_we_q && (rd_q != 5'd0);
                    wb_data_d  = al_data;
                    rd_index_d = rd_q;
                    state_d    = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        dmem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_addr_q  <= '0;
            wb_en_q      <= 1'b0;
            wb_data_q    <= '0;
            rd_index_q   <= '0;
            load_fault_q <= 1'b0;
            fault_addr_q <= '0;
            rd_q         <= '0;
            rd_we_q      <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            dmem_req_q   <= dmem_req_d;
            dmem_addr_q  <= dmem_addr_d;
            wb_en_q      <= wb_en_d;
            wb_data_q    <= wb_data_d;
            rd_index_q   <= rd_index_d;
            load_fault_q <= load_fault_d;
            fault_addr_q <= fault_addr_d;
            rd_q         <= rd_d;
            rd_we_q      <= rd_we_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_addr  = dmem_addr_q;
    assign wb_en      = wb_en_q;
    assign wb_data    = wb_data_q;
    assign rd_index   = rd_index_q;
    assign load_fault = load_fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_wb_unit.sv
// Directed bench for load_wb_unit: non-load throughput, load extraction and
// extension, fault handling, reset during an outstanding load, rd=0 loads.
module tb_load_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr;
    logic [63:0] in_alu_result;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic        dmem_req;
    logic [63:0] dmem_addr;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_en;
    logic [63:0] wb_data;
    logic [4:0]  rd_index;
    logic        load_fault;
    logic [63:0] fault_addr;
    logic        busy;

    int passes = 0;
    int total  = 0;

    load_wb_unit #(.XLEN(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .in_addr       (in_addr),
        .in_alu_result (in_alu_result),
        .in_rd         (in_rd),
        .in_rd_we      (in_rd_we),
        .dmem_req      (dmem_req),
        .dmem_addr     (dmem_addr),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_en         (wb_en),
        .wb_data       (wb_data),
        .rd_index      (rd_index),
        .load_fault    (load_fault),
        .fault_addr    (fault_addr),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic ld, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] alu,
                         input logic [4:0] rd, input logic we);
        in_valid      = v;
        in_is_load    = ld;
        in_funct3     = f3;
        in_addr       = addr;
        in_alu_result = alu;
        in_rd         = rd;
        in_rd_we      = we;
    endtask

    // Issue a load, ack it after 'waits' idle REQ cycles, and check the writeback.
    task automatic load_seq(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [4:0] rd, input logic [63:0] rdata, input int waits,
                            input logic exp_en, input logic [63:0] exp_data);
        drive(1'b1, 1'b1, f3, addr, 64'd0, rd, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        chk({tag, "_req"}, {63'd0, dmem_req}, 64'd1);
        chk({tag, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_rdy_wait"}, {63'd0, in_ready}, 64'd0);
            step();
        end
        chk({tag, "_rdy_req"}, {63'd0, in_ready}, 64'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        step();
        dmem_ack   = 1'b0;
        dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        chk({tag, "_wben"}, {63'd0, wb_en}, {63'd0, exp_en});
        if (exp_en) begin
            chk({tag, "_data"}, wb_data, exp_data);
            chk({tag, "_rd"}, {59'd0, rd_index}, {59'd0, rd});
        end
        chk({tag, "_rdy_wb"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_req_wb"}, {63'd0, dmem_req}, 64'd0);
        step();
        chk({tag, "_wben_off"}, {63'd0, wb_en}, 64'd0);
        chk({tag, "_rdy_back"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'd0;
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        step();
        step();
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_daddr", dmem_addr, 64'd0);
        chk("rst_wben", {63'd0, wb_en}, 64'd0);
        chk("rst_wbdata", wb_data, 64'd0);
        chk("rst_rd", {59'd0, rd_index}, 64'd0);
        chk("rst_fault", {63'd0, load_fault}, 64'd0);
        chk("rst_faddr", fault_addr, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back non-loads
        drive(1'b1, 1'b0, 3'd0, 64'd0, 64'h11, 5'd5, 1'b1);
        step();
        chk("nl0_en", {63'd0, wb_en}, 64'd1);
        chk("nl0_rd", {59'd0, rd_index}, 64'd5);
        chk("nl0_data", wb_data, 64'h11);
        chk("nl0_rdy", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 1'b0, 3'd0, 64'd0, 64'h22, 5'd6, 1'b1);
        step();
        chk("nl1_en", {63'd0, wb_en}, 64'd1);
        chk("nl1_rd", {59'd0, rd_index}, 64'd6);
        chk("nl1_data", wb_data, 64'h22);
        drive(1'b1, 1'b0, 3'd0, 64'd0, 64'h33, 5'd0, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        chk("nl2_en_rd0", {63'd0, wb_en}, 64'd0);
        step();
        chk("nl_idle_en", {63'd0, wb_en}, 64'd0);

        // Loads with extraction and extension
        load_seq("lb",  3'b000, 64'h1007, 5'd7, 64'h80FF_EEDD_CCBB_AA00, 3, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        load_seq("lwu", 3'b110, 64'h2004, 5'd8, 64'h8000_0001_1234_5678, 0, 1'b1, 64'h0000_0000_8000_0001);
        load_seq("lw",  3'b010, 64'h2004, 5'd9, 64'h8000_0001_1234_5678, 1, 1'b1, 64'hFFFF_FFFF_8000_0001);
        load_seq("lhu", 3'b101, 64'h3006, 5'd10, 64'h8001_0000_0000_0000, 0, 1'b1, 64'h0000_0000_0000_8001);
        load_seq("lh",  3'b001, 64'h3002, 5'd11, 64'h0000_0000_F00D_0000, 0, 1'b1, 64'hFFFF_FFFF_FFFF_F00D);
        load_seq("lbu", 3'b100, 64'h1003, 5'd12, 64'h0000_0000_9A00_0000, 0, 1'b1, 64'h0000_0000_0000_009A);
        load_seq("ld",  3'b011, 64'h4010, 5'd13, 64'h0123_4567_89AB_CDEF, 2, 1'b1, 64'h0123_4567_89AB_CDEF);

        // Misaligned and illegal loads
        drive(1'b1, 1'b1, 3'b001, 64'h3001, 64'd0, 5'd4, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        chk("mis_fault", {63'd0, load_fault}, 64'd1);
        chk("mis_faddr", fault_addr, 64'h3001);
        chk("mis_req", {63'd0, dmem_req}, 64'd0);
        chk("mis_wben", {63'd0, wb_en}, 64'd0);
        chk("mis_rdy", {63'd0, in_ready}, 64'd1);
        step();
        chk("mis_pulse_end", {63'd0, load_fault}, 64'd0);
        chk("mis_faddr_hold", fault_addr, 64'h3001);
        drive(1'b1, 1'b1, 3'b111, 64'h5000, 64'd0, 5'd4, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        chk("ill_fault", {63'd0, load_fault}, 64'd1);
        chk("ill_faddr", fault_addr, 64'h5000);
        chk("ill_req", {63'd0, dmem_req}, 64'd0);
        drive(1'b1, 1'b1, 3'b010, 64'h6002, 64'd0, 5'd4, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        chk("lwmis_fault", {63'd0, load_fault}, 64'd1);
        chk("lwmis_faddr", fault_addr, 64'h6002);
        step();

        // Reset while a load is outstanding, then a stray ack
        drive(1'b1, 1'b1, 3'b011, 64'h4008, 64'd0, 5'd9, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        chk("rstld_req", {63'd0, dmem_req}, 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstld_req_off", {63'd0, dmem_req}, 64'd0);
        chk("rstld_busy", {63'd0, busy}, 64'd0);
        step();
        chk("rstld_rdy", {63'd0, in_ready}, 64'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h5555_5555_5555_5555;
        step();
        dmem_ack = 1'b0;
        chk("stray_wben", {63'd0, wb_en}, 64'd0);
        chk("stray_busy", {63'd0, busy}, 64'd0);
        drive(1'b1, 1'b0, 3'd0, 64'd0, 64'h44, 5'd10, 1'b1);
        step();
        drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        chk("after_rst_en", {63'd0, wb_en}, 64'd1);
        chk("after_rst_data", wb_data, 64'h44);
        chk("after_rst_rd", {59'd0, rd_index}, 64'd10);
        step();

        // Load to x0 still reads memory but never writes
        load_seq("ld_x0", 3'b011, 64'h4000, 5'd0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1'b0, 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/load_wb_unit.md
# load_wb_unit

Writeback-side stage of the RV64I pipeline, directly upstream of the register file write port. It accepts retiring instructions from the MEM stage and runs the data-memory read handshake for loads. It aligns and sign- or zero-extends load data, detects misaligned loads, and drives the register file's `wb_en` / `wb_data` / `rd_index` inputs one registered cycle later. While a load is outstanding it back-pressures the MEM stage.

## Interface
Parameters:
- `XLEN`, 64, datapath width; only 64 is supported.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  MEM stage presents an instruction
- `in_ready`  out  1  unit accepts this cycle; a transfer occurs when `in_valid && in_ready`
- `in_is_load`  in  1  instruction is a load
- `in_funct3`  in  3  load size/sign: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 illegal
- `in_addr`  in  64  load effective address
- `in_alu_result`  in  64  writeback value for non-loads
- `in_rd`  in  5  destination register
- `in_rd_we`  in  1  instruction writes `rd`
- `dmem_req`  out  1  read request, held high until acknowledged
- `dmem_addr`  out  64  `{in_addr[63:3], 3'b000}`, stable while `dmem_req` is high
- `dmem_ack`  in  1  `dmem_rdata` valid this cycle
- `dmem_rdata`  in  64  aligned doubleword
- `wb_en`  out  1  register file write enable
- `wb_data`  out  64  register file write data
- `rd_index`  out  5  register file destination
- `load_fault`  out  1  one-cycle pulse: misaligned or illegal load
- `fault_addr`  out  64  address of the last faulting load, held until the next fault
- `busy`  out  1  state is not IDLE

## Operation
- FSM states: IDLE, REQ, WB.
- IDLE: `in_ready=1`.
  - Accepted non-load: next cycle `wb_en = in_rd_we && in_rd!=0`, `wb_data = in_alu_result`, `rd_index = in_rd`. Stays in IDLE, so throughput is 1 per cycle.
  - Accepted aligned load: latch rd, rd_we, funct3 and `addr[2:0]`, then go to REQ.
  - Accepted misaligned or illegal load (funct3=111): no dmem request and no write. `load_fault=1` on the next cycle, `fault_addr` updated. Stays in IDLE.
- Alignment rules:
  - lb/lbu: any address.
  - lh/lhu: `addr[0]==0`.
  - lw/lwu: `addr[1:0]==0`.
  - ld: `addr[2:0]==0`.
- REQ: `dmem_req=1`, `in_ready=0`. On `dmem_ack`, capture the extracted and extended data, then go to WB.
- WB: `wb_en = rd_we && rd!=0` for exactly one cycle, `in_ready=0`. Go to IDLE.
- Extraction uses byte lane `addr[2:0]`:
  - b: byte at `rdata[8*off +: 8]`.
  - h: `rdata[8*off +: 16]`.
  - w: `rdata[8*off +: 32]`.
  - Signed variants replicate the MSB to 64 bits. Unsigned variants zero-fill.
- `dmem_ack` outside REQ is ignored.
- Load with `rd==0` still performs the memory read; `wb_en` stays 0.

## Timing
- Reset values: `in_ready=0` during reset, 1 the cycle after. `dmem_req=0`, `dmem_addr=0`, `wb_en=0`, `wb_data=0`, `rd_index=0`, `load_fault=0`, `fault_addr=0`, `busy=0`. State is IDLE.
- Non-load latency: accept edge N, `wb_en` high during cycle N+1.
- Load latency: accept at N, `dmem_req` high from N+1. With ack in cycle N+k (k≥1), `wb_en` is high in cycle N+k+1 and `in_ready` returns to 1 in cycle N+k+2. A zero-wait memory gives 3 cycles of occupancy per load.
- `wb_*` outputs are registered; the register file writes on the edge that ends the `wb_en` cycle.
- `in_ready` is a function of state only, never of `in_valid`.
- Reset asserted mid-load: the next cycle is IDLE with `dmem_req=0`. The pending write is discarded. A later stray `dmem_ack` has no effect.
- `load_fault` and a `wb_en` for a preceding non-load never coincide, because a fault occupies its own issue slot.

## Structure
- Shared package `rv64_pkg`:
  - funct3 load encodings (`F3_LB`…`F3_LWU`).
  - `wb_state_t` enum {IDLE, REQ, WB}.
  - `XLEN`.
- Sub-module `load_align` (combinational): inputs funct3, offset[2:0], rdata[63:0]; outputs data[63:0] and misaligned. Used both for the alignment check at accept and for extraction at ack.

## Test plan
- Back-to-back non-loads: rd=5 val 0x11, rd=6 val 0x22, rd=0 val 0x33 on consecutive cycles → `wb_en` 1,1,0 on cycles N+1..N+3; `rd_index` 5,6 with matching data.
- lb at addr 0x1007, rdata 0x80FF_..._00 with byte 7 = 0x80, ack after 3 wait cycles → `wb_data=0xFFFF_FFFF_FFFF_FF80`, `dmem_addr=0x1000`, `in_ready` low throughout.
- lwu at 0x2004, rdata[63:32]=0x8000_0001 → `wb_data=0x0000_0000_8000_0001`. The same access as lw gives 0xFFFF_FFFF_8000_0001.
- lh at 0x3001 → `load_fault` pulse, `fault_addr=0x3001`, `dmem_req` never asserted, no `wb_en`. funct3=111 faults the same way.
- Reset asserted while in REQ, then `dmem_ack` pulsed after reset → no `wb_en`, `busy=0`, a following non-load writes normally.
- ld to rd=0 at 0x4000 → `dmem_req` asserted and acked, `wb_en` stays 0, returns to IDLE.
